// File: rtl/tlp_tx_arbiter_if.sv
// Channel-side and core-side signal bundle for the FPGA->Host TLP transmit arbiter.
// The slave modport is the arbiter's view; the master modport is the sources/core view.
interface tlp_tx_arbiter_if #(
    parameter int NUM_CHANS  = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int CW = $clog2(NUM_CHANS);

    logic [NUM_CHANS*DATA_WIDTH-1:0] chanData_in;
    logic [NUM_CHANS-1:0]            chanSOP_in;
    logic [NUM_CHANS-1:0]            chanEOP_in;
    logic [NUM_CHANS-1:0]            chanValid_in;
    logic [NUM_CHANS-1:0]            chanReady_out;
    logic [DATA_WIDTH-1:0]           txData_out;
    logic                            txSOP_out;
    logic                            txEOP_out;
    logic                            txValid_out;
    logic                            txReady_in;
    logic [CW-1:0]                   curChan_out;
    logic                            protoErr_out;

    modport slave (
        input  chanData_in, chanSOP_in, chanEOP_in, chanValid_in, txReady_in,
        output chanReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
               curChan_out, protoErr_out
    );

    modport master (
        output chanData_in, chanSOP_in, chanEOP_in, chanValid_in, txReady_in,
        input  chanReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
               curChan_out, protoErr_out
    );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Round-robin, packet-locked merge of NUM_CHANS TLP sources onto one tx pipe,
// with framing-error detection and a 2-entry output skid buffer.
module tlp_tx_arbiter #(
    parameter int NUM_CHANS  = 4,
    parameter int DATA_WIDTH = 64
) (
    input logic             pcieClk_in,
    input logic             pcieNPOR_in,
    tlp_tx_arbiter_if.slave bus
);
    localparam int CW = $clog2(NUM_CHANS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state;
    logic [CW-1:0]         ptr;
    logic [CW-1:0]         lock_chan;
    logic [CW-1:0]         cur_chan;
    logic                  proto_err;

    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  space;
    logic [DATA_WIDTH-1:0] head_data;
    logic [DATA_WIDTH-1:0] tail_data;
    logic                  head_sop;
    logic                  head_eop;
    logic                  tail_sop;
    logic                  tail_eop;

    logic [CW-1:0]         sel;
    logic                  sel_valid;
    logic                  sel_drop;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_sop;
    logic                  sel_eop;
    logic                  fire;
    logic                  push;
    logic                  pop;
    logic [NUM_CHANS-1:0]  ready;

    function automatic logic [CW-1:0] wrap_chan(input int value);
        return CW'(value % NUM_CHANS);
    endfunction

    // Stray non-SOP beats in IDLE are flushed first (lowest index wins); otherwise the
    // round-robin search runs downward so the entry nearest ptr overrides the rest.
    always_comb begin
        sel       = '0;
        sel_valid = 1'b0;
        sel_drop  = 1'b0;
        if (state == LOCKED) begin
            sel       = lock_chan;
            sel_valid = 1'b1;
        end else begin
            for (int i = NUM_CHANS - 1; i >= 0; i--) begin
                if (bus.chanValid_in[i] && !bus.chanSOP_in[i]) begin
                    sel       = CW'(i);
                    sel_valid = 1'b1;
                    sel_drop  = 1'b1;
                end
            end
            if (!sel_drop) begin
                for (int i = NUM_CHANS - 1; i >= 0; i--) begin
                    if (bus.chanValid_in[wrap_chan(int'(ptr) + i)] &&
                        bus.chanSOP_in[wrap_chan(int'(ptr) + i)]) begin
                        sel       = wrap_chan(int'(ptr) + i);
                        sel_valid = 1'b1;
                    end
                end
            end
        end
    end

    // Ready depends only on the registered space flag, never on txReady_in.
    always_comb begin
        ready = '0;
        if (sel_valid && space) begin
            ready[sel] = 1'b1;
        end
    end

    assign sel_data   = bus.chanData_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_sop    = bus.chanSOP_in[sel];
    assign sel_eop    = bus.chanEOP_in[sel];
    assign fire       = sel_valid && space && bus.chanValid_in[sel];
    assign push       = fire && !sel_drop;
    assign pop        = (count != 2'd0) && bus.txReady_in;
    assign count_next = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge pcieClk_in or negedge pcieNPOR_in) begin
        if (!pcieNPOR_in) begin
            state     <= IDLE;
            ptr       <= '0;
            lock_chan <= '0;
            cur_chan  <= '0;
            proto_err <= 1'b0;
        end else if (fire) begin
            if (sel_drop) begin
                proto_err <= 1'b1;
            end else if (state == IDLE) begin
                cur_chan <= sel;
                if (sel_eop) begin
                    ptr <= wrap_chan(int'(sel) + 1);
                end else begin
                    state     <= LOCKED;
                    lock_chan <= sel;
                end
            end else begin
                if (sel_sop) begin
                    proto_err <= 1'b1;
                end
                if (sel_eop) begin
                    state <= IDLE;
                    ptr   <= wrap_chan(int'(lock_chan) + 1);
                end
            end
        end
    end

    // Head entry drives the tx pipe; the tail only fills while the head is stalled.
    always_ff @(posedge pcieClk_in or negedge pcieNPOR_in) begin
        if (!pcieNPOR_in) begin
            count     <= 2'd0;
            space     <= 1'b0;
            head_data <= '0;
            head_sop  <= 1'b0;
            head_eop  <= 1'b0;
            tail_data <= '0;
            tail_sop  <= 1'b0;
            tail_eop  <= 1'b0;
        end else begin
            count <= count_next;
            space <= (count_next != 2'd2);
            if (pop) begin
                if (count == 2'd2) begin
                    head_data <= tail_data;
                    head_sop  <= tail_sop;
                    head_eop  <= tail_eop;
                end else if (push) begin
                    head_data <= sel_data;
                    head_sop  <= sel_sop;
                    head_eop  <= sel_eop;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_data <= sel_data;
                    head_sop  <= sel_sop;
                    head_eop  <= sel_eop;
                end else begin
                    tail_data <= sel_data;
                    tail_sop  <= sel_sop;
                    tail_eop  <= sel_eop;
                end
            end
        end
    end

    assign bus.chanReady_out = ready;
    assign bus.txValid_out   = (count != 2'd0);
    assign bus.txData_out    = head_data;
    assign bus.txSOP_out     = head_sop && (count != 2'd0);
    assign bus.txEOP_out     = head_eop && (count != 2'd0);
    assign bus.curChan_out   = cur_chan;
    assign bus.protoErr_out  = proto_err;
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed scenarios plus randomized traffic for tlp_tx_arbiter, checked against
// per-channel packet queues, a framing tracker and a round-robin fairness bound.
module tb_tlp_tx_arbiter;
    localparam int NC = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct {
        beat_t b;
        int    cyc;
    } tx_rec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tlp_tx_arbiter_if #(.NUM_CHANS(NC), .DATA_WIDTH(DW)) bus ();

    tlp_tx_arbiter #(.NUM_CHANS(NC), .DATA_WIDTH(DW)) dut (
        .pcieClk_in  (clk),
        .pcieNPOR_in (rst_n),
        .bus         (bus)
    );

    beat_t         srcq[NC][$];
    beat_t         expq[NC][$];
    tx_rec_t       txlog[$];
    logic [NC-1:0] present = '0;
    int            wait_cnt[NC];
    int            pkt_seq[NC];
    int            checks = 0;
    int            errors = 0;
    int            cycle_no = 0;
    int            acc_total = 0;
    int            tx_total = 0;
    int            valid_pct = 100;
    int            ready_pct = 100;
    logic          in_pkt = 1'b0;
    logic [7:0]    in_pkt_ch = '0;
    logic          prev_stall = 1'b0;
    beat_t         held_beat;
    logic [NC-1:0] s_ready;
    logic          s_tx_valid;
    logic [DW-1:0] s_tx_data;

    function automatic logic [DW-1:0] make_data(input int ch, input int pkt, input int beat);
        return {ch[7:0], 8'hA5, pkt[15:0], beat[31:0]};
    endfunction

    function automatic logic pending();
        for (int c = 0; c < NC; c++) begin
            if (srcq[c].size() != 0) return 1'b1;
        end
        return bus.txValid_out;
    endfunction

    task automatic check_output(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_packet(input int ch, input int nbeats);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = make_data(ch, pkt_seq[ch], i);
            b.sop  = (i == 0);
            b.eop  = (i == nbeats - 1);
            srcq[ch].push_back(b);
            expq[ch].push_back(b);
        end
        pkt_seq[ch]++;
    endtask

    task automatic clear_bench();
        for (int c = 0; c < NC; c++) begin
            srcq[c].delete();
            expq[c].delete();
            wait_cnt[c] = 0;
        end
        present    = '0;
        prev_stall = 1'b0;
        in_pkt     = 1'b0;
        bus.chanValid_in = '0;
        bus.chanSOP_in   = '0;
        bus.chanEOP_in   = '0;
        bus.chanData_in  = '0;
    endtask

    // Sources keep valid asserted until their beat is taken.
    task automatic apply_stimulus();
        for (int c = 0; c < NC; c++) begin
            if (!present[c] && srcq[c].size() != 0 && int'($urandom_range(99)) < valid_pct)
                present[c] = 1'b1;
            bus.chanValid_in[c] = present[c];
            if (present[c]) begin
                bus.chanSOP_in[c]           = srcq[c][0].sop;
                bus.chanEOP_in[c]           = srcq[c][0].eop;
                bus.chanData_in[c*DW +: DW] = srcq[c][0].data;
            end else begin
                bus.chanSOP_in[c]           = 1'b0;
                bus.chanEOP_in[c]           = 1'b0;
                bus.chanData_in[c*DW +: DW] = '0;
            end
        end
        bus.txReady_in = (int'($urandom_range(99)) < ready_pct);
    endtask

    task automatic run_cycle();
        logic [NC-1:0] acc;
        int            granted;
        int            ch;
        beat_t         expb;
        beat_t         got;
        acc     = '0;
        granted = -1;
        apply_stimulus();
        @(negedge clk);
        s_ready    = bus.chanReady_out;
        s_tx_valid = bus.txValid_out;
        s_tx_data  = bus.txData_out;
        got.data   = s_tx_data;
        got.sop    = bus.txSOP_out;
        got.eop    = bus.txEOP_out;
        if (prev_stall)
            check_output("tx_hold", 72'({s_tx_valid, got}), 72'({1'b1, held_beat}));
        prev_stall = s_tx_valid && !bus.txReady_in;
        held_beat  = got;
        for (int c = 0; c < NC; c++) begin
            if (present[c] && s_ready[c]) begin
                acc[c] = 1'b1;
                acc_total++;
                if (srcq[c][0].sop) granted = c;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (present[c] && srcq[c][0].sop) begin
                if (c == granted) begin
                    check_output("grant_wait", 72'(wait_cnt[c] < NC), 72'(1));
                    wait_cnt[c] = 0;
                end else if (granted >= 0) begin
                    wait_cnt[c]++;
                end
            end else begin
                wait_cnt[c] = 0;
            end
        end
        if (s_tx_valid && bus.txReady_in) begin
            ch = int'(s_tx_data[63:56]);
            if (ch < NC && expq[ch].size() != 0) expb = expq[ch].pop_front();
            else expb = '0;
            check_output("sb_beat", 72'(got), 72'(expb));
            if (got.sop) begin
                in_pkt_ch = s_tx_data[63:56];
            end else begin
                check_output("no_interleave", 72'({in_pkt, s_tx_data[63:56]}), 72'({1'b1, in_pkt_ch}));
            end
            in_pkt = !got.eop;
            txlog.push_back('{b: got, cyc: cycle_no});
            tx_total++;
        end
        @(posedge clk);
        cycle_no++;
        #1;
        for (int c = 0; c < NC; c++) begin
            if (acc[c]) begin
                void'(srcq[c].pop_front());
                present[c] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (pending() && n < max_cycles) begin
            run_cycle();
            n++;
        end
        check_output("drain_done", 72'(pending()), 72'(0));
    endtask

    initial begin
        int base;
        int pid;
        int acc0;
        int tx0;
        int bexp[5];
        tx_rec_t r;

        for (int c = 0; c < NC; c++) begin
            wait_cnt[c] = 0;
            pkt_seq[c]  = 0;
        end
        bus.txReady_in   = 1'b1;
        bus.chanValid_in = '1;
        bus.chanSOP_in   = '1;
        bus.chanEOP_in   = '0;
        bus.chanData_in  = '1;

        // Reset state with all channels requesting
        #12;
        check_output("rst_ready", 72'(bus.chanReady_out), 72'(0));
        check_output("rst_tx", 72'({bus.txValid_out, bus.txSOP_out, bus.txEOP_out}), 72'(0));
        check_output("rst_data", 72'(bus.txData_out), 72'(0));
        check_output("rst_cur_err", 72'({bus.curChan_out, bus.protoErr_out}), 72'(0));
        clear_bench();
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check_output("post_rst_tx", 72'({bus.txValid_out, bus.chanReady_out}), 72'(0));
        @(posedge clk);
        #1;

        // Four 3-beat packets presented together
        $display("[TB] four simultaneous packets");
        for (int c = 0; c < NC; c++) add_packet(c, 3);
        base = txlog.size();
        drain(100);
        check_output("A_count", 72'(txlog.size() - base), 72'(12));
        for (int k = 0; k < 12 && base + k < txlog.size(); k++) begin
            r = txlog[base + k];
            check_output("A_order", 72'({r.b.data[63:56], r.b.data[31:0], r.b.sop, r.b.eop}),
                         72'({8'(k / 3), 32'(k % 3), (k % 3) == 0, (k % 3) == 2}));
            check_output("A_back2back", 72'(r.cyc), 72'(txlog[base].cyc + k));
        end

        // Single-beat packet on ch2 while ch1/ch3 wait
        $display("[TB] single-beat grant rotation");
        add_packet(1, 1);
        drain(20);
        check_output("B_cur_ch1", 72'(bus.curChan_out), 72'(1));
        add_packet(2, 1);
        add_packet(1, 2);
        add_packet(3, 2);
        base = txlog.size();
        run_cycle();
        check_output("B_cur_ch2", 72'(bus.curChan_out), 72'(2));
        run_cycle();
        check_output("B_cur_ch3", 72'(bus.curChan_out), 72'(3));
        drain(50);
        bexp = '{2, 3, 3, 1, 1};
        check_output("B_count", 72'(txlog.size() - base), 72'(5));
        for (int k = 0; k < 5 && base + k < txlog.size(); k++)
            check_output("B_chan_order", 72'(txlog[base + k].b.data[63:56]), 72'(bexp[k]));

        // Back-pressure mid-packet on ch1
        $display("[TB] stall with locked channel");
        pid  = pkt_seq[1];
        acc0 = acc_total;
        tx0  = tx_total;
        add_packet(1, 6);
        base = txlog.size();
        run_cycle();
        run_cycle();
        ready_pct = 0;
        run_cycle();
        check_output("C_s1_ready", 72'(s_ready), 72'(4'b0010));
        for (int s = 2; s <= 5; s++) begin
            run_cycle();
            check_output("C_ready_zero", 72'(s_ready), 72'(0));
            check_output("C_tx_stable", 72'({s_tx_valid, s_tx_data}), 72'({1'b1, make_data(1, pid, 1)}));
        end
        check_output("C_buffered", 72'((acc_total - acc0) - (tx_total - tx0)), 72'(2));
        ready_pct = 100;
        drain(50);
        check_output("C_count", 72'(txlog.size() - base), 72'(6));
        for (int k = 0; k < 6 && base + k < txlog.size(); k++)
            check_output("C_in_order", 72'(txlog[base + k].b.data), 72'(make_data(1, pid, k)));

        // Stray non-SOP beat in IDLE
        $display("[TB] stray beat drop");
        check_output("D_err_before", 72'(bus.protoErr_out), 72'(0));
        begin
            beat_t b;
            b.data = make_data(0, 999, 0);
            b.sop  = 1'b0;
            b.eop  = 1'b0;
            srcq[0].push_back(b);
        end
        tx0 = tx_total;
        run_cycle();
        check_output("D_drop_ready", 72'(s_ready), 72'(4'b0001));
        check_output("D_err_set", 72'(bus.protoErr_out), 72'(1));
        for (int k = 0; k < 3; k++) run_cycle();
        check_output("D_nothing_tx", 72'({s_tx_valid, 32'(tx_total)}), 72'({1'b0, 32'(tx0)}));

        // Reset on beat 2 of a 4-beat packet
        $display("[TB] mid-packet reset");
        add_packet(0, 4);
        run_cycle();
        run_cycle();
        apply_stimulus();
        #1 rst_n = 1'b0;
        #1;
        check_output("E_rst_ready", 72'(bus.chanReady_out), 72'(0));
        check_output("E_rst_tx", 72'({bus.txValid_out, bus.txSOP_out, bus.txEOP_out, bus.txData_out}), 72'(0));
        check_output("E_rst_cur_err", 72'({bus.curChan_out, bus.protoErr_out}), 72'(0));
        clear_bench();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        pid  = pkt_seq[0];
        base = txlog.size();
        add_packet(0, 2);
        drain(30);
        check_output("E_count", 72'(txlog.size() - base), 72'(2));
        if (txlog.size() > base)
            check_output("E_first_sop", 72'(txlog[base].b), 72'({make_data(0, pid, 0), 1'b1, 1'b0}));

        // Randomized traffic with stalls on both sides
        $display("[TB] random traffic");
        valid_pct = 60;
        ready_pct = 65;
        for (int c = 0; c < NC; c++)
            for (int p = 0; p < 10; p++)
                add_packet(c, 1 + int'($urandom_range(3)));
        drain(6000);
        for (int c = 0; c < NC; c++)
            check_output("F_delivered", 72'(expq[c].size()), 72'(0));
        check_output("F_no_err", 72'(bus.protoErr_out), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlp_tx_arbiter.md
TLP_TX_ARBITER -- requirements
Module: tlp_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CHANS, default 4, range 2..8: number of FPGA->Host TLP source channels.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 64: beat width, matching tlp_xcvr_pkg::uint64 at default.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset: pcieClk_in (in, 1) and pcieNPOR_in (in, 1, async, active-low).
REQ-004 The block SHALL have chanData_in (in, NUM_CHANS*DATA_WIDTH): per-channel beat data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-005 The block SHALL have chanSOP_in, chanEOP_in and chanValid_in (in, NUM_CHANS each): per-channel start-of-packet, end-of-packet and beat-valid.
REQ-006 The block SHALL have chanReady_out (out, NUM_CHANS): per-channel beat accept.
REQ-007 The block SHALL have txData_out (out, DATA_WIDTH), txSOP_out (out, 1), txEOP_out (out, 1) and txValid_out (out, 1): merged pipe toward the PCIe core.
REQ-008 The block SHALL have txReady_in (in, 1): core accept.
REQ-009 The block SHALL have curChan_out (out, $clog2(NUM_CHANS)): channel currently locked, or last granted when idle.
REQ-010 The block SHALL have protoErr_out (out, 1): sticky framing-error flag.

Function
REQ-011 A beat SHALL transfer on any port only in a cycle where valid and ready are both high.
REQ-012 The arbiter FSM SHALL have two states: IDLE and LOCKED.
REQ-013 In IDLE, the block SHALL select the first channel with chanValid_in=1 and chanSOP_in=1, searching round-robin from ptr, and SHALL assert chanReady_out only for that channel, and only when the output buffer has space.
REQ-014 A winning SOP beat without EOP SHALL move the FSM to LOCKED on that channel; a SOP+EOP beat (single-beat TLP) SHALL keep the FSM in IDLE and set ptr to winner+1 mod NUM_CHANS.
REQ-015 In LOCKED, chanReady_out SHALL be high only for the locked channel, gated by buffer space; all other channels SHALL see ready=0 whatever their valid.
REQ-016 An accepted EOP beat in LOCKED SHALL return the FSM to IDLE and set ptr to locked+1 mod NUM_CHANS.
REQ-017 Packets SHALL never interleave on the tx pipe: every SOP..EOP sequence on tx comes from one channel.
REQ-018 In IDLE, a beat with valid=1 and SOP=0 on any channel SHALL be accepted, dropped (not forwarded) and SHALL set protoErr_out; these drops SHALL take priority over the SOP search, one channel per cycle, lowest index first.
REQ-019 In LOCKED, a SOP=1 beat on the locked channel SHALL be forwarded unchanged and SHALL set protoErr_out.
REQ-020 The output stage SHALL be a 2-entry skid buffer; chanReady_out SHALL depend only on registered buffer state, with no combinational path from txReady_in.
REQ-021 Latency SHALL be 1 cycle: a beat accepted in cycle N with the buffer empty SHALL appear on tx outputs in cycle N+1.
REQ-022 Throughput SHALL be 1 beat/cycle while txReady_in stays high.
REQ-023 When txReady_in is low, tx outputs SHALL hold stable until accepted; at most 2 beats SHALL be buffered, after which all chanReady_out SHALL be 0.
REQ-024 protoErr_out SHALL clear only on reset.

Reset
REQ-025 While pcieNPOR_in=0, the block SHALL drive chanReady_out=0, txValid_out=0, txSOP_out=0, txEOP_out=0, txData_out=0, curChan_out=0 and protoErr_out=0, with FSM=IDLE, ptr=0 and buffer empty, all asynchronously.
REQ-026 A reset asserted mid-packet SHALL discard buffered beats with no EOP emitted; after deassertion the first tx beat SHALL be a SOP.
REQ-027 Outputs SHALL be driven from reset-state registers in the first clock edge after deassertion.

Verification
REQ-028 Bench SHALL check: NUM_CHANS=4, channels 0..3 each present a 3-beat TLP in the same cycle, txReady_in=1 -> tx carries ch0, ch1, ch2, ch3 back to back, 12 consecutive valid cycles, no interleave.
REQ-029 Bench SHALL check: ch2 sends a single-beat TLP (SOP=EOP=1) while ch1 and ch3 are valid -> next grant is ch3, curChan_out=3.
REQ-030 Bench SHALL check: ch1 locked mid-packet, txReady_in=0 for 5 cycles -> exactly 2 beats buffered, chanReady_out=0000, tx beat stable; on release, data is in order with none lost.
REQ-031 Bench SHALL check: ch0 valid with SOP=0 in IDLE -> beat dropped, protoErr_out=1 next cycle, nothing on tx.
REQ-032 Bench SHALL check: pcieNPOR_in pulled low on beat 2 of a 4-beat TLP -> outputs 0 immediately; after release, a new TLP from ch0 emerges with SOP on its first tx beat.
REQ-033 Bench SHALL check: random valid/txReady_in stall sequences across all channels -> scoreboard shows per-channel packet order preserved and each channel granted within NUM_CHANS packets of requesting.
